pipeline_ctrl: RTL

- Central sequencing controller for the 5-stage MIPS pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Merges debug-unit commands (run, single-step, pause) with load-use stall, branch/jump flush and HALT-instruction drain.
- Produces per-stage clock-enable and flush strobes.
- Sits between the debug unit and the datapath; replaces scattered enable/flush wiring.

---
 rtl/pipeline_ctrl_pkg.sv | 22 ++
 rtl/pipeline_ctrl_if.sv | 52 +++++
 rtl/pipeline_ctrl_hazard_detect.sv | 26 ++
 rtl/pipeline_ctrl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl_pkg
// Description : Shared state encodings and defaults for the pipeline
//               sequencing controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_ctrl_pkg;

  localparam int NB_STATE         = 3;
  localparam int DRAIN_CYCLES_DEF = 3;

  typedef enum logic [NB_STATE-1:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/pipeline_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl_if
// Description : Debug-unit / datapath bundle seen by the pipeline controller.
//               master = debug unit + datapath side, slave = controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_ctrl_if #(
  parameter int NB_ADDR = 5,
  parameter int NB_CNT  = 32
);

  // Debug commands
  logic               i_run;
  logic               i_step;
  logic               i_pause;
  // Datapath status
  logic               i_halt_instr;
  logic               i_branch_taken;
  logic               i_id_ex_mem_read;
  logic [NB_ADDR-1:0] i_id_ex_rt_addr;
  logic [NB_ADDR-1:0] i_if_id_rs_addr;
  logic [NB_ADDR-1:0] i_if_id_rt_addr;
  // Stage controls
  logic               o_pc_en;
  logic               o_if_id_en;
  logic               o_id_ex_en;
  logic               o_ex_mem_en;
  logic               o_mem_wb_en;
  logic               o_if_id_flush;
  logic               o_id_ex_flush;
  // Status
  logic [2:0]         o_state;
  logic [NB_CNT-1:0]  o_cycle_count;
  logic               o_done;

  modport master (
    output i_run, i_step, i_pause, i_halt_instr, i_branch_taken,
           i_id_ex_mem_read, i_id_ex_rt_addr, i_if_id_rs_addr, i_if_id_rt_addr,
    input  o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en,
           o_if_id_flush, o_id_ex_flush, o_state, o_cycle_count, o_done
  );

  modport slave (
    input  i_run, i_step, i_pause, i_halt_instr, i_branch_taken,
           i_id_ex_mem_read, i_id_ex_rt_addr, i_if_id_rs_addr, i_if_id_rt_addr,
    output o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en,
           o_if_id_flush, o_id_ex_flush, o_state, o_cycle_count, o_done
  );

endinterface
`default_nettype wire

// File: rtl/pipeline_ctrl_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detect
// Description : Load-use hazard compare between the load in EX and the
//               source registers of the instruction in ID.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect #(
  parameter int NB_ADDR = 5
) (
  input  wire logic               i_mem_read,
  input  wire logic [NB_ADDR-1:0] i_ex_rt_addr,
  input  wire logic [NB_ADDR-1:0] i_id_rs_addr,
  input  wire logic [NB_ADDR-1:0] i_id_rt_addr,
  output logic                    o_stall
);

  // Register 0 is hard-wired, so a load targeting it never creates a hazard
  always_comb begin
    o_stall = i_mem_read
            && (i_ex_rt_addr != '0)
            && ((i_ex_rt_addr == i_id_rs_addr) || (i_ex_rt_addr == i_id_rt_addr));
  end

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl
// Description : Central sequencer for PC and pipeline registers. Merges debug
//               run/step/pause with load-use stall, branch flush and HALT
//               drain into per-stage enable and flush strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int NB_ADDR      = 5,
  parameter int NB_CNT       = 32,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  wire logic       i_clk,
  input  wire logic       i_reset,
  pipeline_ctrl_if.slave  bus
);

  localparam int NB_DRAIN = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [NB_DRAIN-1:0] DRAIN_LAST = NB_DRAIN'(DRAIN_CYCLES - 1);

  state_e              state_q, state_d;
  logic [NB_DRAIN-1:0] drain_q, drain_d;
  logic [NB_CNT-1:0]   cycle_q, cycle_d;
  logic                done_q,  done_d;

  logic w_stall;
  logic w_adv;
  logic w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en, w_mem_wb_en;
  logic w_if_id_flush, w_id_ex_flush;

  hazard_detect #(
    .NB_ADDR (NB_ADDR)
  ) u_hazard_detect (
    .i_mem_read   (bus.i_id_ex_mem_read),
    .i_ex_rt_addr (bus.i_id_ex_rt_addr),
    .i_id_rs_addr (bus.i_if_id_rs_addr),
    .i_id_rt_addr (bus.i_if_id_rt_addr),
    .o_stall      (w_stall)
  );

  assign w_adv = (state_q == ST_RUN) || (state_q == ST_STEP) || (state_q == ST_DRAIN);

  // Next-state logic: command arbitration, drain countdown, saturating cycle count
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    cycle_d = cycle_q;
    done_d  = done_q;

    if (w_adv && (cycle_q != '1)) begin
      cycle_d = cycle_q + NB_CNT'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.i_run) begin
          state_d = ST_RUN;
        end else if (bus.i_step) begin
          state_d = ST_STEP;
        end
      end
      ST_RUN: begin
        // HALT beats a coincident pause so the drain is never skipped
        if (bus.i_halt_instr) begin
          state_d = ST_DRAIN;
          drain_d = '0;
        end else if (bus.i_pause) begin
          state_d = ST_IDLE;
        end
      end
      ST_STEP: begin
        if (bus.i_halt_instr) begin
          state_d = ST_DRAIN;
          drain_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = ST_HALTED;
          drain_d = '0;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q + NB_DRAIN'(1);
        end
      end
      ST_HALTED: begin
        done_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        drain_d = '0;
        done_d  = 1'b0;
      end
    endcase
  end

  // State, drain counter, cycle counter and done flag
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      drain_q <= '0;
      cycle_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      cycle_q <= cycle_d;
      done_q  <= done_d;
    end
  end

  // Stage strobes; flushes stay low when not advancing because the pipeline
  // registers give flush priority over enable and would lose held state
  always_comb begin
    w_pc_en       = 1'b0;
    w_if_id_en    = 1'b0;
    w_id_ex_en    = 1'b0;
    w_ex_mem_en   = 1'b0;
    w_mem_wb_en   = 1'b0;
    w_if_id_flush = 1'b0;
    w_id_ex_flush = 1'b0;

    if (state_q == ST_DRAIN) begin
      w_id_ex_en    = 1'b1;
      w_ex_mem_en   = 1'b1;
      w_mem_wb_en   = 1'b1;
      w_id_ex_flush = 1'b1;
    end else if ((state_q == ST_RUN) || (state_q == ST_STEP)) begin
      w_id_ex_en  = 1'b1;
      w_ex_mem_en = 1'b1;
      w_mem_wb_en = 1'b1;
      if (bus.i_halt_instr || w_stall) begin
        // Freeze the front end and bubble EX; a pending branch is
        // re-evaluated once the stall clears
        w_id_ex_flush = 1'b1;
      end else begin
        w_pc_en       = 1'b1;
        w_if_id_en    = 1'b1;
        w_if_id_flush = bus.i_branch_taken;
      end
    end
  end

  assign bus.o_pc_en       = w_pc_en;
  assign bus.o_if_id_en    = w_if_id_en;
  assign bus.o_id_ex_en    = w_id_ex_en;
  assign bus.o_ex_mem_en   = w_ex_mem_en;
  assign bus.o_mem_wb_en   = w_mem_wb_en;
  assign bus.o_if_id_flush = w_if_id_flush;
  assign bus.o_id_ex_flush = w_id_ex_flush;
  assign bus.o_state       = state_q;
  assign bus.o_cycle_count = cycle_q;
  assign bus.o_done        = done_q;

endmodule
`default_nettype wire
